// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: operand forwarding, ALU, destination select,
// and the registered results/control handed to MEM. Supports stall (hold) and flush (bubble).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int AW_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       instrIn,
  input  logic [DATA_W-1:0] DaIn,
  input  logic [DATA_W-1:0] DbIn,
  input  logic [1:0]        ALUcntrlIn,
  input  logic              ALUSrcIn,
  input  logic              RegDestIn,
  input  logic              RegWrIn,
  input  logic              MemWrIn,
  input  logic              MemToRegIn,
  input  logic              wbRegWr,
  input  logic [AW_W-1:0]   wbAw,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] AluResOut,
  output logic [DATA_W-1:0] DbOut,
  output logic [AW_W-1:0]   AwOut,
  output logic              RegWrOut,
  output logic              MemWrOut,
  output logic              MemToRegOut,
  output logic              ZeroOut,
  output logic              OvfOut,
  output logic              validOut
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] db;
    logic [AW_W-1:0]   aw;
    logic              rw;
    logic              mw;
    logic              m2r;
    logic              zero;
    logic              ovf;
    logic              valid;
  } exmem_t;

  exmem_t exmem_q, exmem_d;

  logic [AW_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;
  logic [AW_W-1:0]   src_addr [2];
  logic [DATA_W-1:0] rf_val   [2];
  logic [DATA_W-1:0] fwd_val  [2];
  logic              unused_opcode;

  assign rs      = instrIn[21 +: AW_W];
  assign rt      = instrIn[16 +: AW_W];
  assign rd      = instrIn[11 +: AW_W];
  assign imm_ext = {{(DATA_W-16){instrIn[15]}}, instrIn[15:0]};
  assign unused_opcode = ^instrIn[31:26];

  assign src_addr[0] = rs;
  assign src_addr[1] = rt;
  assign rf_val[0]   = DaIn;
  assign rf_val[1]   = DbIn;

  // The EX/MEM copy is younger than MEM/WB, so it wins; $0 is hardwired zero and never forwarded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd_val[gi] = rf_val[gi];
      if (src_addr[gi] != '0) begin
        if (exmem_q.rw && exmem_q.valid && (exmem_q.aw == src_addr[gi]))
          fwd_val[gi] = exmem_q.alu;
        else if (wbRegWr && (wbAw == src_addr[gi]))
          fwd_val[gi] = wbData;
      end
    end
  end

  logic [DATA_W-1:0] op_a, op_b, sum, diff, alu_res;
  logic              ovf;

  assign op_a = fwd_val[0];
  assign op_b = ALUSrcIn ? imm_ext : fwd_val[1];
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (ALUcntrlIn)
      2'b00: begin
        alu_res = sum;
        ovf     = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      2'b01: begin
        alu_res = diff;
        ovf     = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
      end
      2'b10:   alu_res = op_a ^ op_b;
      default: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    endcase
  end

  always_comb begin
    exmem_d       = '0;
    exmem_d.alu   = alu_res;
    exmem_d.db    = fwd_val[1];
    exmem_d.aw    = RegDestIn ? rd : rt;
    exmem_d.rw    = RegWrIn && !ovf;
    exmem_d.mw    = MemWrIn;
    exmem_d.m2r   = MemToRegIn;
    exmem_d.zero  = (alu_res == '0);
    exmem_d.ovf   = ovf;
    exmem_d.valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush)
      exmem_q <= '0;
    else if (!stall)
      exmem_q <= exmem_d;
  end

  assign AluResOut   = exmem_q.alu;
  assign DbOut       = exmem_q.db;
  assign AwOut       = exmem_q.aw;
  assign RegWrOut    = exmem_q.rw;
  assign MemWrOut    = exmem_q.mw;
  assign MemToRegOut = exmem_q.m2r;
  assign ZeroOut     = exmem_q.zero;
  assign OvfOut      = exmem_q.ovf;
  assign validOut    = exmem_q.valid;

endmodule
